rot_loader: RTL
===============

// Module: rot_loader
// PURPOSE
//  Upstream feeder for the N-bit barrel rotator.
//  - Assembles an N-bit vector from N/W narrow input beats, using a valid/ready handshake.
//  - Captures the rotate amount k on the first beat of each vector.
//  - Presents the complete vector and k, held stable, to the rotator's combinational inputs.
//  - Holds them until the downstream consumer accepts, then reloads.
// PARAMETERS
//  N       256  vector width in bits; power of two; must equal the rotator's N
//  log2_N  8    log2(N); width of k
//  W       32   input beat width; power of two; W <= N; N % W == 0
//  (derived) BEATS = N/W beats per vector; counter width = max(1, log2(BEATS))
// PORTS
//  clk        in   1         clock; all state updates on the rising edge
//  rst        in   1         asynchronous reset, active-high
//  clr        in   1         synchronous flush; drops the partial or held vector
//  in_data    in   [0:W-1]   input beat
//  in_valid   in   1         in_data/k_in valid
//  in_ready   out  1         loader accepts a beat this cycle
//  k_in       in   [0:log2_N-1]  rotate amount; sampled only on beat 0
//  bits_out   out  [0:N-1]   assembled vector -> rotator "bits"
//  k_out      out  [0:log2_N-1]  captured k -> rotator "k"
//  out_valid  out  1         bits_out/k_out complete and stable
//  out_ready  in   1         downstream has consumed the rotated result
// BEHAVIOUR
//  Reset (async, rst=1)
//  - state=LOAD, beat=0, bits_out=0, k_out=0, out_valid=0, in_ready=1 (once rst deasserts).
//  - Asserting rst mid-load or while FULL discards all data immediately.
//  FSM: LOAD, FULL
//  - in_ready = (state==LOAD) & ~clr; out_valid = (state==FULL). Both are pure state decodes, no comb path from in_valid/out_ready.
//  LOAD
//  - Beat handshake (in_valid & in_ready): bits_out[beat*W + i] <= in_data[i] for i=0..W-1.
//  - Beat 0 fills bits_out[0:W-1], so in_data[0] lands at bits_out[0].
//  - If beat==0: k_out <= k_in. Later beats ignore k_in.
//  - beat < BEATS-1: beat <= beat+1.
//  - beat == BEATS-1: beat <= 0, state <= FULL. out_valid rises in the cycle after the last handshake.
//  - in_valid low: no change. Gaps of any length are legal.
//  FULL
//  - bits_out and k_out do not change. in_ready=0.
//  - out_ready=1: state <= LOAD. in_ready rises in the next cycle.
//  - The handshake is out_valid & out_ready. Minimum period is BEATS+1 cycles per vector.
//  clr
//  - Highest priority after rst. Next state LOAD, beat=0, out_valid=0.
//  - bits_out/k_out keep their stale contents. They are don't-care while out_valid=0.
//  - A beat presented in the same cycle as clr is not accepted (in_ready=0).
//  Bits not yet written in a partial vector hold the previous vector's values; do not clear them.
//  BEATS==1 (W==N): every accepted beat goes LOAD->FULL directly.
//  Rotator use: rotated result = bits_out rotated per k_out. The result is valid exactly while out_valid=1.
//  The rotator itself lies outside this block.
// TESTING
//  All scenarios use N=256, W=32.
//  1 Basic: 8 back-to-back beats, in_data=beat index (32'h0..32'h7), k_in=8'd5 on beat 0
//    -> out_valid=1 the cycle after beat 7; bits_out[224:255]=32'h7; k_out=5.
//  2 k sampling: k_in=3 on beat 0, k_in=200 on beats 1-7
//    -> k_out=3; a rotator fed from the loader outputs the vector rotated by 3.
//  3 Backpressure: out_ready=0 for 5 cycles after FULL
//    -> out_valid and bits_out constant; in_ready=0 throughout; in_ready=1 the cycle after out_ready=1.
//  4 Gaps: in_valid toggles 1,0,0,1,... over 8 beats -> same bits_out as scenario 1; no extra or lost beats.
//  5 Reset mid-load: rst pulse after 3 beats, then 8 new beats of 32'hFFFF_FFFF
//    -> out_valid=0 during and after rst; final bits_out = all ones; exactly 8 beats needed.
//  6 clr while FULL, with in_valid held at 1 in the same cycle
//    -> that beat is not taken; out_valid=0 next cycle; 8 fresh beats are required before out_valid returns.

Source files
------------

// File: rtl/rot_loader.sv
// Feeder for the N-bit barrel rotator: gathers N/W beats into one vector and
// captures the rotate amount on beat 0, then holds both until downstream accepts.
module rot_loader #(
  parameter int N      = 256,
  parameter int log2_N = 8,
  parameter int W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [0:W-1]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:log2_N-1] k_in,
  output logic [0:N-1]      bits_out,
  output logic [0:log2_N-1] k_out,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int BEATS = N / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {LOAD, FULL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] beat, beat_nxt;
  logic          take;
  logic          last_beat;

  // Pure state decodes: no combinational path from in_valid/out_ready.
  assign in_ready  = (state == LOAD) & ~clr;
  assign out_valid = (state == FULL);
  assign take      = in_valid & in_ready;
  assign last_beat = (beat == CW'(BEATS - 1));

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    if (clr) begin
      state_nxt = LOAD;
      beat_nxt  = '0;
    end else begin
      case (state)
        LOAD: begin
          if (take) begin
            if (last_beat) begin
              state_nxt = FULL;
              beat_nxt  = '0;
            end else begin
              beat_nxt = beat + 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) state_nxt = LOAD;
        end
        default: begin
          state_nxt = LOAD;
          beat_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // Unwritten lanes of a partial vector deliberately keep the previous vector's bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_out <= '0;
      k_out    <= '0;
    end else if (take) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (beat == CW'(b)) bits_out[b*W +: W] <= in_data;
      end
      if (beat == '0) k_out <= k_in;
    end
  end

endmodule
